// File: rtl/uart_core_if.sv
// FIFO-side bundle of uart_core: TX valid/ready handshake in, received word and status out.
interface uart_core_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 tx_busy;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_frame_err;
   logic                 rx_parity_err;
   logic                 rx_break;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_break
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_break
   );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART engine: TX serialiser and 16x-oversampled RX deserialiser with runtime
// divisor, 5..8 data bits, optional parity, one/two stop bits, framing/parity/break flags.
//
// state      | meaning
// TX_IDLE    | line high, tx_ready=1, waiting for tx_valid
// TX_START   | driving start bit (0)
// TX_DATA    | shifting DATA_BITS data bits, LSB first
// TX_PARITY  | driving parity bit
// TX_STOP1   | first stop bit (1)
// TX_STOP2   | second stop bit when two_stop was set at accept
// RX_IDLE    | waiting for a synchronised falling edge while armed
// RX_START   | validating start bit at its majority point
// RX_DATA    | sampling data bits
// RX_PARITY  | sampling parity bit
// RX_STOP    | sampling stop bit, result published at its majority point
module uart_core #(
   parameter int DATA_BITS = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic                 tx,
   input  logic                 rx,
   uart_core_if.slave           bus
);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   logic [DIV_WIDTH-1:0] div_eff;
   logic                 par_en, par_odd;

   assign div_eff = (divisor == '0) ? DIV_ONE : divisor;
   assign par_en  = parity_mode[0] ^ parity_mode[1];
   assign par_odd = (parity_mode == 2'b10);

   tx_state_t            tx_state, tx_next;
   logic [DIV_WIDTH-1:0] tx_div, tx_pre;
   logic [3:0]           tx_tcnt;
   logic [DATA_BITS-1:0] tx_shift;
   logic [2:0]           tx_bcnt;
   logic                 tx_par_en, tx_par_bit, tx_two;
   logic                 tx_accept, tx_tick, tx_bit_end;

   assign tx_accept  = (tx_state == TX_IDLE) && bus.tx_valid;
   assign tx_tick    = (tx_pre >= tx_div - DIV_ONE);
   assign tx_bit_end = tx_tick && (tx_tcnt == 4'd0);

   always_ff @(posedge clk) begin
      if (reset) tx_state <= TX_IDLE;
      else       tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:   if (bus.tx_valid) tx_next = TX_START;
         TX_START:  if (tx_bit_end) tx_next = TX_DATA;
         TX_DATA:   if (tx_bit_end && tx_bcnt == 3'd0) tx_next = tx_par_en ? TX_PARITY : TX_STOP1;
         TX_PARITY: if (tx_bit_end) tx_next = TX_STOP1;
         TX_STOP1:  if (tx_bit_end) tx_next = tx_two ? TX_STOP2 : TX_IDLE;
         TX_STOP2:  if (tx_bit_end) tx_next = TX_IDLE;
         default:   tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (tx_state)
         TX_START:  tx = 1'b0;
         TX_DATA:   tx = tx_shift[0];
         TX_PARITY: tx = tx_par_bit;
         default:   tx = 1'b1;
      endcase
   end

   assign bus.tx_ready = (tx_state == TX_IDLE);
   assign bus.tx_busy  = (tx_state != TX_IDLE);

   // tx_tcnt counts bit ticks down; 0 is the terminal tick and wraps back to 15.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_div     <= '0;
         tx_pre     <= '0;
         tx_tcnt    <= 4'd0;
         tx_shift   <= '0;
         tx_bcnt    <= 3'd0;
         tx_par_en  <= 1'b0;
         tx_par_bit <= 1'b0;
         tx_two     <= 1'b0;
      end else if (tx_accept) begin
         tx_div     <= div_eff;
         tx_par_en  <= par_en;
         tx_par_bit <= (^bus.tx_data) ^ par_odd;
         tx_two     <= two_stop;
         tx_shift   <= bus.tx_data;
         tx_bcnt    <= 3'(DATA_BITS - 1);
         tx_pre     <= '0;
         tx_tcnt    <= 4'd15;
      end else if (tx_state != TX_IDLE) begin
         if (tx_tick) begin
            tx_pre  <= '0;
            tx_tcnt <= tx_tcnt - 4'd1;
            if (tx_tcnt == 4'd0 && tx_state == TX_DATA) begin
               tx_shift <= tx_shift >> 1;
               tx_bcnt  <= tx_bcnt - 3'd1;
            end
         end else begin
            tx_pre <= tx_pre + DIV_ONE;
         end
      end
   end

   rx_state_t            rx_state, rx_next;
   logic                 rx_s1, rx_s2, rx_s3;
   logic [DIV_WIDTH-1:0] rx_div, rx_pre, rx_div_sel;
   logic [3:0]           rx_tcnt;
   logic [DATA_BITS-1:0] rx_shift;
   logic [2:0]           rx_bcnt;
   logic                 rx_par_en, rx_odd, rx_par_bit, rx_smp7, rx_smp8, rx_armed;
   logic                 rx_tick, rx_mid, rx_end, rx_bit, rx_start;
   logic                 rx_done, rx_fe_c, rx_pe_c, rx_brk_c;

   assign rx_div_sel = (rx_state == RX_IDLE) ? div_eff : rx_div;
   assign rx_tick    = (rx_pre >= rx_div_sel - DIV_ONE);
   assign rx_mid     = rx_tick && (rx_tcnt == 4'd9);
   assign rx_end     = rx_tick && (rx_tcnt == 4'd15);
   assign rx_bit     = (rx_smp7 & rx_smp8) | (rx_smp7 & rx_s2) | (rx_smp8 & rx_s2);
   assign rx_start   = (rx_state == RX_IDLE) && rx_armed && rx_s3 && !rx_s2;

   always_ff @(posedge clk) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:   if (rx_start) rx_next = RX_START;
         RX_START:  if (rx_mid && rx_bit) rx_next = RX_IDLE;
                    else if (rx_end) rx_next = RX_DATA;
         RX_DATA:   if (rx_end && rx_bcnt == 3'd0) rx_next = rx_par_en ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_end) rx_next = RX_STOP;
         RX_STOP:   if (rx_mid) rx_next = RX_IDLE;
         default:   rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_done  = (rx_state == RX_STOP) && rx_mid;
      rx_fe_c  = !rx_bit;
      rx_pe_c  = rx_par_en && ((^rx_shift) ^ rx_odd ^ rx_par_bit);
      rx_brk_c = (rx_shift == '0) && !(rx_par_en && rx_par_bit) && !rx_bit;
   end

   // Sync flops reset low so the line must be seen high before the receiver arms.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1             <= 1'b0;
         rx_s2             <= 1'b0;
         rx_s3             <= 1'b0;
         rx_div            <= '0;
         rx_pre            <= '0;
         rx_tcnt           <= 4'd0;
         rx_shift          <= '0;
         rx_bcnt           <= 3'd0;
         rx_par_en         <= 1'b0;
         rx_odd            <= 1'b0;
         rx_par_bit        <= 1'b0;
         rx_smp7           <= 1'b0;
         rx_smp8           <= 1'b0;
         rx_armed          <= 1'b0;
         bus.rx_data       <= '0;
         bus.rx_valid      <= 1'b0;
         bus.rx_frame_err  <= 1'b0;
         bus.rx_parity_err <= 1'b0;
         bus.rx_break      <= 1'b0;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
         if (rx_start) begin
            rx_pre     <= '0;
            rx_tcnt    <= 4'd0;
            rx_div     <= div_eff;
            rx_par_en  <= par_en;
            rx_odd     <= par_odd;
            rx_par_bit <= 1'b0;
            rx_bcnt    <= 3'(DATA_BITS - 1);
         end else if (rx_tick) begin
            rx_pre  <= '0;
            rx_tcnt <= rx_tcnt + 4'd1;
         end else begin
            rx_pre <= rx_pre + DIV_ONE;
         end
         if (rx_tick && rx_tcnt == 4'd7) rx_smp7 <= rx_s2;
         if (rx_tick && rx_tcnt == 4'd8) rx_smp8 <= rx_s2;
         if (rx_state == RX_DATA && rx_mid) rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
         if (rx_state == RX_DATA && rx_end) rx_bcnt <= rx_bcnt - 3'd1;
         if (rx_state == RX_PARITY && rx_mid) rx_par_bit <= rx_bit;
         bus.rx_valid <= rx_done;
         if (rx_done) begin
            bus.rx_data       <= rx_shift;
            bus.rx_frame_err  <= rx_fe_c;
            bus.rx_parity_err <= rx_pe_c;
            bus.rx_break      <= rx_brk_c;
         end
         if (rx_done && !rx_bit)  rx_armed <= 1'b0;
         else if (rx_tick && rx_s2) rx_armed <= 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: TX pattern/length checks, RX vector table, corner sequences,
// randomized simultaneous TX/RX against a frame-level model, and a 7-bit loopback instance.
module tb_uart_core;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] divisor;
   logic [1:0]  parity_mode;
   logic        two_stop;
   logic        tx8, rx8;
   logic [15:0] div7;
   logic [1:0]  pm7;
   logic        ts7;
   logic        tx7;

   uart_core_if #(.DATA_BITS(8)) bus8();
   uart_core_if #(.DATA_BITS(7)) bus7();

   uart_core #(.DATA_BITS(8), .DIV_WIDTH(16)) u_dut (
      .clk(clk), .reset(reset), .divisor(divisor), .parity_mode(parity_mode),
      .two_stop(two_stop), .tx(tx8), .rx(rx8), .bus(bus8)
   );

   uart_core #(.DATA_BITS(7), .DIV_WIDTH(16)) u_loop (
      .clk(clk), .reset(reset), .divisor(div7), .parity_mode(pm7),
      .two_stop(ts7), .tx(tx7), .rx(tx7), .bus(bus7)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       fe, pe, brk;
   } rx_rec_t;

   typedef struct {
      logic [7:0] d;
      int         div;
      logic [1:0] pm;
      bit         stop_val;
      bit         flip;
      logic [7:0] e_d;
      bit         e_fe, e_pe, e_brk;
   } rx_vec_t;

   rx_rec_t q8[$];
   rx_rec_t q7[$];
   int      n_chk = 0;
   int      n_fail = 0;
   int      dbl = 0;
   bit      prev8 = 0, prev7 = 0;

   always @(negedge clk) begin
      rx_rec_t r;
      if (bus8.rx_valid) begin
         r.d = bus8.rx_data; r.fe = bus8.rx_frame_err; r.pe = bus8.rx_parity_err; r.brk = bus8.rx_break;
         q8.push_back(r);
      end
      if (bus7.rx_valid) begin
         r.d = {1'b0, bus7.rx_data}; r.fe = bus7.rx_frame_err; r.pe = bus7.rx_parity_err; r.brk = bus7.rx_break;
         q7.push_back(r);
      end
      if ((bus8.rx_valid && prev8) || (bus7.rx_valid && prev7)) dbl = dbl + 1;
      prev8 = bus8.rx_valid;
      prev7 = bus7.rx_valid;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Serial frame as the line carries it: start, data LSB first, optional parity, stop(s).
   function automatic int frame_bits(input logic [7:0] d, input int nb, input logic [1:0] pm,
                                     input bit two, input bit stop_val, input bit flip,
                                     output logic [15:0] bits);
      int n;
      bit p;
      bits = '1;
      n = 0;
      p = 0;
      bits[n] = 1'b0; n++;
      for (int i = 0; i < nb; i++) begin
         bits[n] = d[i];
         p = p ^ d[i];
         n++;
      end
      if (pm == 2'b01 || pm == 2'b10) begin
         bits[n] = p ^ (pm == 2'b10) ^ flip;
         n++;
      end
      bits[n] = stop_val; n++;
      if (two) begin bits[n] = 1'b1; n++; end
      return n;
   endfunction

   function automatic rx_rec_t rx_model(input logic [7:0] d, input logic [1:0] pm,
                                        input bit stop_val, input bit flip);
      rx_rec_t r;
      bit pen, sent;
      pen  = (pm == 2'b01 || pm == 2'b10);
      sent = (pm == 2'b10) ^ flip;
      for (int i = 0; i < 8; i++) sent = sent ^ d[i];
      r.d   = d;
      r.fe  = !stop_val;
      r.pe  = pen && flip;
      r.brk = (d == 8'h00) && !(pen && sent) && !stop_val;
      return r;
   endfunction

   task automatic send_rx(input logic [7:0] d, input int div, input logic [1:0] pm,
                          input bit stop_val, input bit flip, input int spike_bit);
      logic [15:0] bits;
      int n;
      n = frame_bits(d, 8, pm, 1'b0, stop_val, flip, bits);
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < 16 * div; c++) begin
            rx8 = (b == spike_bit && c == 8 * div) ? ~bits[b] : bits[b];
            step();
         end
      end
      rx8 = 1'b1;
      repeat (16 * div) step();
   endtask

   task automatic check_rx(input string name, input rx_rec_t e);
      rx_rec_t r;
      chk({name, "_count"}, q8.size(), 1);
      if (q8.size() > 0) begin
         r = q8.pop_front();
         chk({name, "_data"}, r.d, e.d);
         chk({name, "_frame_err"}, r.fe, e.fe);
         chk({name, "_parity_err"}, r.pe, e.pe);
         chk({name, "_break"}, r.brk, e.brk);
      end
   endtask

   task automatic tx_check(input string name, input logic [7:0] d, input int div,
                           input logic [1:0] pm, input bit two, input int new_div);
      logic [15:0] bits;
      int n, len, errs, first;
      n = frame_bits(d, 8, pm, two, 1'b1, 1'b0, bits);
      len = n * 16 * div;
      divisor = 16'(div); parity_mode = pm; two_stop = two;
      bus8.tx_data = d; bus8.tx_valid = 1'b1;
      step();
      bus8.tx_valid = 1'b0;
      if (new_div != 0) divisor = 16'(new_div);
      errs = 0; first = -1;
      for (int i = 0; i < len; i++) begin
         if (tx8 !== bits[i / (16 * div)] || bus8.tx_ready !== 1'b0 || bus8.tx_busy !== 1'b1) begin
            errs++;
            if (first < 0) first = i;
         end
         step();
      end
      chk({name, "_bad_cycles"}, errs, 0);
      chk({name, "_ready_after"}, bus8.tx_ready, 1'b1);
      chk({name, "_idle_line"}, tx8, 1'b1);
   endtask

   initial begin
      rx_vec_t    tbl[10];
      rx_rec_t    e;
      bit         exp_a5[10];
      logic [7:0] lb[3];
      int         cnt, errs, div;
      logic [1:0] pm;
      bit         two, flip, sv;
      logic [7:0] td, rd;

      tbl[0] = '{8'h3C, 1, 2'b00, 1, 0, 8'h3C, 0, 0, 0};
      tbl[1] = '{8'hA5, 2, 2'b01, 1, 0, 8'hA5, 0, 0, 0};
      tbl[2] = '{8'h5A, 1, 2'b01, 1, 1, 8'h5A, 0, 1, 0};
      tbl[3] = '{8'h81, 1, 2'b10, 1, 0, 8'h81, 0, 0, 0};
      tbl[4] = '{8'hFF, 2, 2'b10, 1, 1, 8'hFF, 0, 1, 0};
      tbl[5] = '{8'h0F, 1, 2'b00, 0, 0, 8'h0F, 1, 0, 0};
      tbl[6] = '{8'h00, 1, 2'b00, 0, 0, 8'h00, 1, 0, 1};
      tbl[7] = '{8'h00, 1, 2'b01, 0, 0, 8'h00, 1, 0, 1};
      tbl[8] = '{8'h00, 1, 2'b10, 0, 0, 8'h00, 1, 0, 0};
      tbl[9] = '{8'hC3, 1, 2'b11, 1, 0, 8'hC3, 0, 0, 0};
      exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      lb = '{8'h00, 8'h7F, 8'h55};

      reset = 1'b1; rx8 = 1'b1; divisor = 16'd1; parity_mode = 2'b00; two_stop = 1'b0;
      bus8.tx_data = '0; bus8.tx_valid = 1'b0;
      div7 = 16'd3; pm7 = 2'b10; ts7 = 1'b1;
      bus7.tx_data = '0; bus7.tx_valid = 1'b0;
      repeat (3) step();
      chk("reset_tx", tx8, 1'b1);
      chk("reset_tx_ready", bus8.tx_ready, 1'b1);
      chk("reset_tx_busy", bus8.tx_busy, 1'b0);
      chk("reset_rx_data", bus8.rx_data, 8'h00);
      chk("reset_rx_valid", bus8.rx_valid, 1'b0);
      chk("reset_flags", {bus8.rx_frame_err, bus8.rx_parity_err, bus8.rx_break}, 3'b000);
      reset = 1'b0;
      repeat (10) step();

      // 0xA5 8N1 at divisor 1: fixed pattern, 16 clk per bit.
      bus8.tx_data = 8'hA5; bus8.tx_valid = 1'b1;
      step();
      bus8.tx_valid = 1'b0;
      cnt = 0; errs = 0;
      while (bus8.tx_ready === 1'b0 && cnt < 1000) begin
         if (cnt < 160 && tx8 !== exp_a5[cnt / 16]) errs++;
         cnt++;
         step();
      end
      chk("a5_ready_low_cycles", cnt, 160);
      chk("a5_pattern_errors", errs, 0);

      for (int i = 0; i < 10; i++) begin
         divisor = 16'(tbl[i].div); parity_mode = tbl[i].pm;
         q8.delete();
         send_rx(tbl[i].d, tbl[i].div, tbl[i].pm, tbl[i].stop_val, tbl[i].flip, -1);
         e.d = tbl[i].e_d; e.fe = tbl[i].e_fe; e.pe = tbl[i].e_pe; e.brk = tbl[i].e_brk;
         check_rx($sformatf("rx_vec%0d", i), e);
      end

      divisor = 16'd1; parity_mode = 2'b00;
      q8.delete();
      rx8 = 1'b0; repeat (5) step();
      rx8 = 1'b1; repeat (60) step();
      chk("false_start_no_valid", q8.size(), 0);

      send_rx(8'h96, 1, 2'b00, 1'b1, 1'b0, 3);
      e.d = 8'h96; e.fe = 0; e.pe = 0; e.brk = 0;
      check_rx("spike", e);

      // Line held low for three frame times.
      rx8 = 1'b0; repeat (480) step();
      e.d = 8'h00; e.fe = 1; e.pe = 0; e.brk = 1;
      check_rx("break", e);
      rx8 = 1'b1; repeat (40) step();
      chk("break_no_retrigger", q8.size(), 0);
      send_rx(8'h42, 1, 2'b00, 1'b1, 1'b0, -1);
      e.d = 8'h42; e.fe = 0; e.pe = 0; e.brk = 0;
      check_rx("after_break", e);

      // Reset in the middle of both a TX and an RX frame.
      q8.delete();
      bus8.tx_data = 8'hFF; bus8.tx_valid = 1'b1;
      step();
      bus8.tx_valid = 1'b0;
      rx8 = 1'b0; repeat (16) step();
      rx8 = 1'b1; repeat (20) step();
      reset = 1'b1;
      step();
      chk("midreset_tx", tx8, 1'b1);
      chk("midreset_tx_ready", bus8.tx_ready, 1'b1);
      chk("midreset_rx_valid", bus8.rx_valid, 1'b0);
      reset = 1'b0;
      rx8 = 1'b0; repeat (40) step();
      rx8 = 1'b1; repeat (40) step();
      chk("midreset_no_rx_frame", q8.size(), 0);
      chk("midreset_tx_idle", tx8, 1'b1);

      tx_check("divchg_frame", 8'h3C, 1, 2'b00, 1'b0, 2);
      tx_check("divchg_next", 8'h3C, 2, 2'b00, 1'b0, 0);

      for (int it = 0; it < 10; it++) begin
         div  = int'($urandom_range(1, 2));
         pm   = 2'($urandom_range(0, 3));
         two  = 1'($urandom_range(0, 1));
         td   = 8'($urandom);
         rd   = 8'($urandom);
         flip = ($urandom_range(0, 3) == 0);
         sv   = ($urandom_range(0, 4) != 0);
         divisor = 16'(div); parity_mode = pm; two_stop = two;
         q8.delete();
         fork
            tx_check($sformatf("rand%0d_tx", it), td, div, pm, two, 0);
            send_rx(rd, div, pm, sv, flip, -1);
         join
         e = rx_model(rd, pm, sv, flip);
         check_rx($sformatf("rand%0d_rx", it), e);
      end

      // 7-bit odd parity two-stop loopback, valid held across frames.
      q7.delete();
      bus7.tx_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus7.tx_data = lb[k][6:0];
         step();
         cnt = 0;
         while (bus7.tx_ready === 1'b0 && cnt < 2000) begin
            cnt++;
            step();
         end
         chk($sformatf("loop%0d_frame_cycles", k), cnt, 11 * 48);
      end
      bus7.tx_valid = 1'b0;
      repeat (20) step();
      chk("loop_rx_count", q7.size(), 3);
      for (int k = 0; k < 3; k++) begin
         if (q7.size() > 0) begin
            e = q7.pop_front();
            chk($sformatf("loop%0d_data", k), e.d, lb[k]);
            chk($sformatf("loop%0d_flags", k), {e.fe, e.pe, e.brk}, 3'b000);
         end
      end

      chk("rx_valid_single_cycle", dbl, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
